// File: rtl/systolic_array_if.sv
// systolic_array_if: operand/result bundle for the systolic matrix-multiply core.
//   a_in[i] / valid_a[i] : row i operand entering the left edge
//   b_in[j] / valid_b[j] : column j operand entering the top edge
//   out[i][j]            : accumulator of PE[i][j]
// master: the feeder/readout side; slave: the array itself.
interface systolic_array_if #(
  parameter int SIZE      = 3,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
);
  logic [SIZE-1:0][IN_WIDTH-1:0]             a_in;
  logic [SIZE-1:0]                           valid_a;
  logic [SIZE-1:0][IN_WIDTH-1:0]             b_in;
  logic [SIZE-1:0]                           valid_b;
  logic [SIZE-1:0][SIZE-1:0][OUT_WIDTH-1:0]  out;

  modport master (output a_in, valid_a, b_in, valid_b, input out);
  modport slave  (input a_in, valid_a, b_in, valid_b, output out);
endinterface

// File: rtl/systolic_array.sv
// systolic_array: output-stationary SIZE x SIZE unsigned MAC array.
// Rows of A enter from the left, columns of B from the top, both pre-skewed
// by the caller. Each PE accumulates its C element in place; accumulators
// are only cleared by reset.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset, clears accumulators and pipelines
//   bus   : systolic_array_if slave (operands in, accumulators out)
module systolic_array #(
  parameter int SIZE      = 3,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  systolic_array_if.slave   bus
);

  // a_fwd[i][j] is the registered a-output of PE[i][j], consumed by PE[i][j+1];
  // b_fwd[i][j] is the registered b-output of PE[i][j], consumed by PE[i+1][j].
  logic [SIZE-1:0][SIZE-2:0][IN_WIDTH-1:0] a_fwd;
  logic [SIZE-1:0][SIZE-2:0]               va_fwd;
  logic [SIZE-2:0][SIZE-1:0][IN_WIDTH-1:0] b_fwd;
  logic [SIZE-2:0][SIZE-1:0]               vb_fwd;

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      logic [IN_WIDTH-1:0]   a_pe;
      logic [IN_WIDTH-1:0]   b_pe;
      logic                  va_pe;
      logic                  vb_pe;
      logic [2*IN_WIDTH-1:0] prod;
      logic [OUT_WIDTH-1:0]  acc;

      if (gj == 0) begin : g_a_edge
        assign a_pe  = bus.a_in[gi];
        assign va_pe = bus.valid_a[gi];
      end else begin : g_a_int
        assign a_pe  = a_fwd[gi][gj-1];
        assign va_pe = va_fwd[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_pe  = bus.b_in[gj];
        assign vb_pe = bus.valid_b[gj];
      end else begin : g_b_int
        assign b_pe  = b_fwd[gi-1][gj];
        assign vb_pe = vb_fwd[gi-1][gj];
      end

      // Full-width unsigned product; the accumulate wraps modulo 2^OUT_WIDTH.
      assign prod = {{IN_WIDTH{1'b0}}, a_pe} * {{IN_WIDTH{1'b0}}, b_pe};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          acc <= '0;
        end else if (va_pe && vb_pe) begin
          acc <= acc + OUT_WIDTH'(prod);
        end
      end

      assign bus.out[gi][gj] = acc;

      // Forwarding registers load every cycle regardless of valids. The
      // right-most column and bottom row have no downstream consumer, so
      // their outgoing registers are not built.
      if (gj < SIZE-1) begin : g_a_fwd
        logic [IN_WIDTH-1:0] a_q;
        logic                va_q;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            a_q  <= '0;
            va_q <= 1'b0;
          end else begin
            a_q  <= a_pe;
            va_q <= va_pe;
          end
        end
        assign a_fwd[gi][gj]  = a_q;
        assign va_fwd[gi][gj] = va_q;
      end

      if (gi < SIZE-1) begin : g_b_fwd
        logic [IN_WIDTH-1:0] b_q;
        logic                vb_q;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            b_q  <= '0;
            vb_q <= 1'b0;
          end else begin
            b_q  <= b_pe;
            vb_q <= vb_pe;
          end
        end
        assign b_fwd[gi][gj]  = b_q;
        assign vb_fwd[gi][gj] = vb_q;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_array_if #(.SIZE(N), .IN_WIDTH(8), .OUT_WIDTH(32)) bus ();
  systolic_array_if #(.SIZE(N), .IN_WIDTH(8), .OUT_WIDTH(16)) bus16 ();

  systolic_array #(.SIZE(N), .IN_WIDTH(8), .OUT_WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  systolic_array #(.SIZE(N), .IN_WIDTH(8), .OUT_WIDTH(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mat_a [N][N];
  logic [7:0] mat_b [N][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pair k meets at PE[i][j] on edge k+i+j+1 when the first operands land on
  // edge 1, so after edge e the accumulator holds the partial dot product
  // over every k that has arrived by then.
  function automatic longint unsigned model_acc(input int i, input int j, input int e);
    longint unsigned s = 0;
    for (int k = 0; k < N; k++)
      if (k + i + j + 1 <= e)
        s += longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
    return s % 64'h1_0000_0000;
  endfunction

  task automatic idle_inputs();
    bus.valid_a = '0;
    bus.valid_b = '0;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus16.valid_a = '0;
    bus16.valid_b = '0;
    bus16.a_in    = '0;
    bus16.b_in    = '0;
  endtask

  // Skewed feed: A[i][k] at cycle k+i, B[k][j] at cycle k+j; garbage data
  // when the valid is low.
  task automatic drive_cycle(input int c);
    for (int i = 0; i < N; i++) begin
      int k = c - i;
      if (k >= 0 && k < N) begin
        bus.a_in[i]    = mat_a[i][k];
        bus.valid_a[i] = 1'b1;
      end else begin
        bus.a_in[i]    = 8'($urandom);
        bus.valid_a[i] = 1'b0;
      end
    end
    for (int j = 0; j < N; j++) begin
      int k = c - j;
      if (k >= 0 && k < N) begin
        bus.b_in[j]    = mat_b[k][j];
        bus.valid_b[j] = 1'b1;
      end else begin
        bus.b_in[j]    = 8'($urandom);
        bus.valid_b[j] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag, input int e);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_e%0d_c%0d%0d", tag, e, i, j), bus.out[i][j], model_acc(i, j, e));
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), bus.out[i][j], 0);
  endtask

  // Runs the product to completion plus 6 idle edges, checking every
  // element after every edge; stops early after stop_edge if nonzero.
  task automatic run_product(input string tag, input int stop_edge);
    for (int e = 1; e <= 3*N - 2 + 6; e++) begin
      drive_cycle(e - 1);
      @(posedge clk);
      #1;
      check_all(tag, e);
      if (e == stop_edge) return;
    end
    idle_inputs();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_c [9];
    reset = 1'b0;
    idle_inputs();

    // Reset holds everything at zero across an edge.
    @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // Directed 3x3 product with A = B = [[1,2,3],[4,5,6],[7,8,9]].
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 8'(i*N + j + 1);
        mat_b[i][j] = 8'(i*N + j + 1);
      end
    run_product("dir", 0);
    exp_c = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("dir_final_c%0d%0d", i, j), bus.out[i][j], exp_c[i*N + j]);

    // Mid-run asynchronous reset, then a full rerun.
    apply_reset();
    run_product("mid", 4);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    reset = 1'b1;
    run_product("rerun", 0);

    // Random matrices, including the full 0..255 operand range.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          mat_a[i][j] = (t == 3) ? 8'd255 : 8'($urandom_range(0, 255));
          mat_b[i][j] = (t == 3) ? 8'd255 : 8'($urandom_range(0, 255));
        end
      apply_reset();
      run_product($sformatf("rnd%0d", t), 0);
    end

    // Valid gating: only one side valid must never accumulate.
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      bus.a_in[0]    = 8'($urandom_range(1, 255));
      bus.b_in[0]    = 8'($urandom_range(1, 255));
      bus.valid_a[0] = 1'b1;
      bus.valid_b[0] = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("gate_a_only%0d", n), bus.out[0][0], 0);
    end
    for (int n = 0; n < 3; n++) begin
      bus.a_in[0]    = 8'($urandom_range(1, 255));
      bus.b_in[0]    = 8'($urandom_range(1, 255));
      bus.valid_a[0] = 1'b0;
      bus.valid_b[0] = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("gate_b_only%0d", n), bus.out[0][0], 0);
    end
    idle_inputs();

    // Wrap-around on the 16-bit accumulator instance.
    apply_reset();
    bus16.a_in[0]    = 8'd255;
    bus16.b_in[0]    = 8'd255;
    bus16.valid_a[0] = 1'b1;
    bus16.valid_b[0] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("wrap16_n%0d", n), bus16.out[0][0], (n * 65025) % 65536);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    check("wrap16_hold", bus16.out[0][0], (5 * 65025) % 65536);
    check("wrap16_c11", bus16.out[1][1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
